kbd_led_controller: RTL and testbench
=====================================

# kbd_led_controller

Keyboard lock-state controller placed between the scancode front end and the keycode-to-ASCII converter. It tracks modifier and lock state from decoded key events and drives the modifier inputs the converter needs. Whenever a lock state changes, it runs the PS/2 host "Set LEDs" command sequence (0xED, LED byte) on the shared transmitter, with ACK checking, resend handling and timeout retries.

## Interface
- `TIMEOUT_CYCLES`, 1000000: cycles to wait for each keyboard response (10 ms at 100 MHz).
- `RETRIES`, 2: extra transmit attempts per byte after a timeout or resend request.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_data_stb`  in  1  decoded key event strobe, one cycle, from the scancode converter.
- `key_broken`  in  1  1 = release event, 0 = make event; valid with `key_data_stb`.
- `key_data`  in  8  set-2 keycode; valid with `key_data_stb`.
- `rx_stb`  in  1  raw byte received from the keyboard.
- `rx_data`  in  8  received byte; valid with `rx_stb`.
- `tx_ready`  in  1  PS/2 transmitter idle and able to accept a byte.
- `tx_stb`  out  1  one-cycle request to send `tx_data`.
- `tx_data`  out  8  byte to transmit.
- `caps_enabled`  out  1  Caps Lock state.
- `shift_enabled`  out  1  left OR right shift held.
- `alt_enabled`  out  1  Alt held.
- `num_enabled`, `scroll_enabled`  out  1  Num/Scroll Lock state.
- `busy`  out  1  LED sequence in progress.
- `err_stb`  out  1  one-cycle pulse when a sequence is abandoned.

## Operation
- Keycodes used:
  - 0x12 and 0x59: left and right shift, tracked separately.
  - 0x11: Alt.
  - 0x58: Caps Lock.
  - 0x77: Num Lock.
  - 0x7E: Scroll Lock.
  - All other keycodes are ignored.
- Shift and Alt follow make/release directly.
- A lock key toggles its state on a make only when that key is not already held. A per-lock held flag is cleared on release, so typematic repeats do not toggle.
- Any lock toggle sets `pending`.
- FSM states:
  - IDLE: if `pending`, clear `pending` and go to SEND_CMD.
  - SEND_CMD: when `tx_ready`, pulse `tx_stb` with 0xED, then go to WAIT_ACK1.
  - WAIT_ACK1: on `rx_stb` with 0xFA, go to SEND_LED.
  - SEND_LED: when `tx_ready`, pulse `tx_stb` with the LED byte, then go to WAIT_ACK2.
  - WAIT_ACK2: on 0xFA, go to IDLE.
- LED byte is {5'b0, caps, num, scroll}, sampled in the cycle `tx_stb` is asserted.
- In either WAIT state:
  - `rx_data` 0xFE (resend) or a timeout returns to the matching SEND state, provided attempts remain.
  - When attempts are exhausted, pulse `err_stb` and return to IDLE.
  - Any other received byte is ignored.
- The attempt counter resets to 0 on every SEND_CMD/SEND_LED entry from a non-retry path. It allows `RETRIES`+1 total sends per byte.
- Key events are processed in every state. A toggle during a sequence sets `pending`, so one more sequence follows and the final LED byte always matches the lock state.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values: all state outputs 0, `tx_stb` 0, `tx_data` 0x00, `busy` 0, `err_stb` 0, `pending` 0, FSM in IDLE.
- Reset mid-sequence abandons the sequence silently: no `err_stb`, no `tx_stb`.
- Modifier and lock outputs update on the clock edge that samples `key_data_stb`, so they are visible one cycle later.
- `tx_stb` is asserted no earlier than one cycle after entering SEND_*, and only while `tx_ready`=1. `tx_data` holds its value until the next `tx_stb`.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on WAIT_* entry and on any `rx_stb`.
  - Expiry fires on the cycle the count reaches TIMEOUT_CYCLES-1 without an ACK.
- Simultaneous ACK and timeout in the same cycle: the ACK wins.
- Simultaneous lock toggle and IDLE→SEND_CMD transition: `pending` ends set, and the new sequence's LED byte reflects the toggle.

## Configuration
- `KBD_LED_NUMSCROLL_EN` defined: Num and Scroll Lock are tracked as described above.
- Undefined:
  - Keycodes 0x77 and 0x7E are ignored.
  - `num_enabled` and `scroll_enabled` are tied to 0.
  - LED byte bits 1:0 are always 0.
  - Only Caps Lock triggers sequences.

## Structure
- A shared package holds:
  - The keycode constants (KC_LSHIFT, KC_RSHIFT, KC_ALT, KC_CAPS, KC_NUM, KC_SCROLL).
  - The PS/2 constants (CMD_SET_LEDS=0xED, RSP_ACK=0xFA, RSP_RESEND=0xFE).
  - The FSM state enum.
- One sub-module, `kbd_mod_tracker`, holds the modifier/lock registers, held flags and toggle detection, and emits the `toggle` pulse.
- The top-level module contains the command FSM, retry logic and timeout counter.

## Test plan
- Caps make, then caps break: `caps_enabled` becomes 1. Tx sequence is 0xED, then (after ACK 0xFA) 0x04. A second ACK returns `busy` to 0.
- Three caps makes without a break (typematic), then a break: exactly one toggle and one sequence.
- Left shift make, right shift make, left shift break: `shift_enabled` stays 1 until the right shift break.
- 0xFE reply to 0xED: 0xED is retransmitted. 0xFE three times with RETRIES=2: `err_stb` pulses, FSM returns to IDLE, `busy`=0.
- No reply with TIMEOUT_CYCLES=100: retransmit after 100 cycles. Caps toggled during WAIT_ACK2: a second sequence sends 0x00.
- Num make with `KBD_LED_NUMSCROLL_EN` defined gives LED byte 0x02. Undefined: no sequence and `num_enabled`=0. Reset asserted in WAIT_ACK1 clears all outputs with no `err_stb`.

Source files
------------

// File: rtl/kbd_led_controller_pkg.sv
// Shared constants and types for the keyboard lock-state / LED controller.
package kbd_led_controller_pkg;

  localparam logic [7:0] KC_LSHIFT = 8'h12;
  localparam logic [7:0] KC_RSHIFT = 8'h59;
  localparam logic [7:0] KC_ALT    = 8'h11;
  localparam logic [7:0] KC_CAPS   = 8'h58;
  localparam logic [7:0] KC_NUM    = 8'h77;
  localparam logic [7:0] KC_SCROLL = 8'h7E;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_ACK1,
    ST_SEND_LED,
    ST_WAIT_ACK2
  } led_state_e;

  function automatic logic [7:0] led_byte(input logic caps, input logic num, input logic scroll);
    return {5'b0, caps, num, scroll};
  endfunction

endpackage

// File: rtl/kbd_led_controller_if.sv
// Key-event, receive and transmit handshake bundle between the PS/2 front end and the LED controller.
interface kbd_led_controller_if;
  logic       key_data_stb;
  logic       key_broken;
  logic [7:0] key_data;
  logic       rx_stb;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_stb;
  logic [7:0] tx_data;

  modport master (
    output key_data_stb, key_broken, key_data, rx_stb, rx_data, tx_ready,
    input  tx_stb, tx_data
  );

  modport slave (
    input  key_data_stb, key_broken, key_data, rx_stb, rx_data, tx_ready,
    output tx_stb, tx_data
  );
endinterface

// File: rtl/kbd_mod_tracker.sv
// Modifier and lock-state registers with typematic-safe lock toggling.
// KBD_LED_NUMSCROLL_EN adds Num/Scroll Lock tracking; otherwise only Caps Lock exists.
module kbd_mod_tracker
  import kbd_led_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_stb,
  input  logic       key_broken,
  input  logic [7:0] key_data,
  output logic       shift,
  output logic       alt,
  output logic       caps,
  output logic       num,
  output logic       scroll,
  output logic       toggle
);

`ifdef KBD_LED_NUMSCROLL_EN
  localparam int NLOCK = 3;
`else
  localparam int NLOCK = 1;
`endif
  // Lock index 0 = Caps, 1 = Num, 2 = Scroll.
  localparam logic [7:0] LOCK_KC [3] = '{KC_CAPS, KC_NUM, KC_SCROLL};

  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             alt_q, alt_d;
  logic [NLOCK-1:0] lock_q, lock_d;
  logic [NLOCK-1:0] held_q, held_d;

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    alt_d    = alt_q;
    lock_d   = lock_q;
    held_d   = held_q;
    toggle   = 1'b0;
    if (key_stb) begin
      case (key_data)
        KC_LSHIFT: lshift_d = ~key_broken;
        KC_RSHIFT: rshift_d = ~key_broken;
        KC_ALT:    alt_d    = ~key_broken;
        default:   ;
      endcase
      for (int i = 0; i < NLOCK; i++) begin
        if (key_data == LOCK_KC[i]) begin
          if (key_broken) begin
            held_d[i] = 1'b0;
          end else if (!held_q[i]) begin
            // Only the first make of a press toggles; repeats see held set.
            held_d[i] = 1'b1;
            lock_d[i] = ~lock_q[i];
            toggle    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      alt_q    <= 1'b0;
      lock_q   <= '0;
      held_q   <= '0;
    end else begin
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      alt_q    <= alt_d;
      lock_q   <= lock_d;
      held_q   <= held_d;
    end
  end

  assign shift = lshift_q | rshift_q;
  assign alt   = alt_q;
  assign caps  = lock_q[0];
`ifdef KBD_LED_NUMSCROLL_EN
  assign num    = lock_q[1];
  assign scroll = lock_q[2];
`else
  assign num    = 1'b0;
  assign scroll = 1'b0;
`endif

endmodule

// File: rtl/kbd_led_controller.sv
// Keyboard lock-state controller: runs the PS/2 Set-LEDs sequence (0xED, LED byte)
// with ACK checking, resend and timeout retries whenever a lock state changes.
module kbd_led_controller
  import kbd_led_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RETRIES        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kbd_led_controller_if.slave  bus,
  output logic                 caps_enabled,
  output logic                 shift_enabled,
  output logic                 alt_enabled,
  output logic                 num_enabled,
  output logic                 scroll_enabled,
  output logic                 busy,
  output logic                 err_stb
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  led_state_e  state_q, state_d;
  logic        pending_q, pending_d;
  logic [AW-1:0] att_q, att_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        err_q, err_d;
  logic        tx_stb;
  logic        toggle;
  logic        in_wait, timeout, ack, retry;

  kbd_mod_tracker u_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_stb    (bus.key_data_stb),
    .key_broken (bus.key_broken),
    .key_data   (bus.key_data),
    .shift      (shift_enabled),
    .alt        (alt_enabled),
    .caps       (caps_enabled),
    .num        (num_enabled),
    .scroll     (scroll_enabled),
    .toggle     (toggle)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    att_d     = att_q;
    tmo_d     = '0;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    tx_stb    = 1'b0;

    in_wait = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);
    // Any received byte restarts the wait window, so it also masks expiry.
    timeout = in_wait && !bus.rx_stb && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    ack     = in_wait && bus.rx_stb && (bus.rx_data == RSP_ACK);
    retry   = in_wait && (timeout || (bus.rx_stb && bus.rx_data == RSP_RESEND));
    if (in_wait && !bus.rx_stb) tmo_d = tmo_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          att_d     = '0;
          state_d   = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (bus.tx_ready) begin
          tx_stb    = 1'b1;
          tx_data_d = CMD_SET_LEDS;
          state_d   = ST_WAIT_ACK1;
        end
      end
      ST_SEND_LED: begin
        if (bus.tx_ready) begin
          tx_stb    = 1'b1;
          tx_data_d = led_byte(caps_enabled, num_enabled, scroll_enabled);
          state_d   = ST_WAIT_ACK2;
        end
      end
      ST_WAIT_ACK1, ST_WAIT_ACK2: begin
        if (ack) begin
          att_d   = '0;
          state_d = (state_q == ST_WAIT_ACK1) ? ST_SEND_LED : ST_IDLE;
        end else if (retry) begin
          if (att_q == AW'(RETRIES)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            att_d   = att_q + 1'b1;
            state_d = (state_q == ST_WAIT_ACK1) ? ST_SEND_CMD : ST_SEND_LED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A toggle coinciding with the IDLE launch still queues one more sequence.
    if (toggle) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      att_q     <= '0;
      tmo_q     <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      att_q     <= att_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.tx_stb  = tx_stb;
  assign bus.tx_data = tx_data_d;
  assign busy        = (state_q != ST_IDLE);
  assign err_stb     = err_q;

endmodule

// File: tb/tb_kbd_led_controller.sv
// Directed self-checking bench for kbd_led_controller (TIMEOUT_CYCLES=100, RETRIES=2).
module tb_kbd_led_controller;
  import kbd_led_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kbd_led_controller_if kif();
  logic caps, shift, alt, num, scroll, busy, err;

  kbd_led_controller #(.TIMEOUT_CYCLES(100), .RETRIES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (kif),
    .caps_enabled   (caps),
    .shift_enabled  (shift),
    .alt_enabled    (alt),
    .num_enabled    (num),
    .scroll_enabled (scroll),
    .busy           (busy),
    .err_stb        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int errs = 0;
  logic [7:0] txq[$];
  int txc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.tx_stb === 1'b1) begin
      txq.push_back(kif.tx_data);
      txc.push_back(cyc);
    end
    if (err === 1'b1) errs <= errs + 1;
  end

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  function automatic int txt(input int i);
    if (i < txc.size()) return txc[i];
    return -1;
  endfunction

  task automatic key(input logic [7:0] kc, input logic brk);
    @(posedge clk); #1;
    kif.key_data_stb = 1'b1; kif.key_data = kc; kif.key_broken = brk;
    @(posedge clk); #1;
    kif.key_data_stb = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    @(posedge clk); #1;
    kif.rx_stb = 1'b1; kif.rx_data = b;
    @(posedge clk); #1;
    kif.rx_stb = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 3000 && txq.size() < n; k++) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_cmp++; if ({caps, shift, alt, num, scroll} !== 5'b0) begin n_bad++; $display("FAIL reset_state: got %b want 00000", {caps, shift, alt, num, scroll}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (kif.tx_stb !== 1'b0 || kif.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx: got stb=%b data=%h want 0/00", kif.tx_stb, kif.tx_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_caps;
    txq.delete(); txc.delete();
    key(KC_CAPS, 1'b0);
    n_cmp++; if (caps !== 1'b1) begin n_bad++; $display("FAIL caps_make: got %b want 1", caps); end
    key(KC_CAPS, 1'b1);
    wait_tx(1);
    n_cmp++; if (txb(0) !== 8'hED) begin n_bad++; $display("FAIL caps_cmd: got %h want ed", txb(0)); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL caps_busy: got %b want 1", busy); end
    rx(RSP_ACK);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'h04) begin n_bad++; $display("FAIL caps_led: got %h want 04", txb(1)); end
    rx(RSP_ACK);
    idle(3);
    n_cmp++; if (busy !== 1'b0 || txq.size() != 2) begin n_bad++; $display("FAIL caps_done: got busy=%b ntx=%0d want 0/2", busy, txq.size()); end
  endtask

  task automatic test_typematic;
    txq.delete(); txc.delete();
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b0);
    n_cmp++; if (caps !== 1'b0) begin n_bad++; $display("FAIL typematic_caps: got %b want 0", caps); end
    key(KC_CAPS, 1'b1);
    wait_tx(1);
    rx(RSP_ACK);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'h00) begin n_bad++; $display("FAIL typematic_led: got %h want 00", txb(1)); end
    rx(RSP_ACK);
    idle(20);
    n_cmp++; if (txq.size() != 2 || busy !== 1'b0) begin n_bad++; $display("FAIL typematic_once: got ntx=%0d busy=%b want 2/0", txq.size(), busy); end
  endtask

  task automatic test_shift_alt;
    txq.delete(); txc.delete();
    key(KC_LSHIFT, 1'b0);
    n_cmp++; if (shift !== 1'b1) begin n_bad++; $display("FAIL lshift_make: got %b want 1", shift); end
    key(KC_RSHIFT, 1'b0);
    key(KC_LSHIFT, 1'b1);
    n_cmp++; if (shift !== 1'b1) begin n_bad++; $display("FAIL lshift_break_rheld: got %b want 1", shift); end
    key(KC_RSHIFT, 1'b1);
    n_cmp++; if (shift !== 1'b0) begin n_bad++; $display("FAIL rshift_break: got %b want 0", shift); end
    key(KC_ALT, 1'b0);
    n_cmp++; if (alt !== 1'b1) begin n_bad++; $display("FAIL alt_make: got %b want 1", alt); end
    key(KC_ALT, 1'b1);
    n_cmp++; if (alt !== 1'b0) begin n_bad++; $display("FAIL alt_break: got %b want 0", alt); end
    idle(5);
    n_cmp++; if (txq.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL modifier_no_seq: got ntx=%0d busy=%b want 0/0", txq.size(), busy); end
  endtask

  task automatic test_resend;
    int e0;
    txq.delete(); txc.delete();
    e0 = errs;
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b1);
    wait_tx(1);
    rx(RSP_RESEND);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'hED) begin n_bad++; $display("FAIL resend_cmd: got %h want ed", txb(1)); end
    rx(RSP_RESEND);
    wait_tx(3);
    rx(RSP_RESEND);
    idle(5);
    n_cmp++; if (errs - e0 != 1) begin n_bad++; $display("FAIL resend_err: got %0d pulses want 1", errs - e0); end
    n_cmp++; if (busy !== 1'b0 || txq.size() != 3) begin n_bad++; $display("FAIL resend_abandon: got busy=%b ntx=%0d want 0/3", busy, txq.size()); end
  endtask

  task automatic test_timeout;
    // caps 1 -> 0; first 0xED unanswered, retransmitted after the wait window
    txq.delete(); txc.delete();
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b1);
    wait_tx(1);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'hED) begin n_bad++; $display("FAIL timeout_cmd: got %h want ed", txb(1)); end
    n_cmp++; if (txt(1) - txt(0) != 101) begin n_bad++; $display("FAIL timeout_gap: got %0d cycles want 101", txt(1) - txt(0)); end
    rx(RSP_ACK);
    wait_tx(3);
    n_cmp++; if (txb(2) !== 8'h00) begin n_bad++; $display("FAIL timeout_led: got %h want 00", txb(2)); end
    rx(RSP_ACK);
    idle(5);
    // caps 0 -> 1, then toggled back to 0 while waiting for the LED ACK
    txq.delete(); txc.delete();
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b1);
    wait_tx(1);
    rx(RSP_ACK);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'h04) begin n_bad++; $display("FAIL mid_led1: got %h want 04", txb(1)); end
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b1);
    n_cmp++; if (caps !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_toggle: got caps=%b busy=%b want 0/1", caps, busy); end
    rx(RSP_ACK);
    wait_tx(3);
    rx(RSP_ACK);
    wait_tx(4);
    n_cmp++; if (txb(2) !== 8'hED || txb(3) !== 8'h00) begin n_bad++; $display("FAIL mid_second_seq: got %h %h want ed 00", txb(2), txb(3)); end
    rx(RSP_ACK);
    idle(5);
    n_cmp++; if (busy !== 1'b0 || txq.size() != 4) begin n_bad++; $display("FAIL mid_done: got busy=%b ntx=%0d want 0/4", busy, txq.size()); end
  endtask

  task automatic test_num;
    txq.delete(); txc.delete();
    key(KC_NUM, 1'b0);
`ifdef KBD_LED_NUMSCROLL_EN
    n_cmp++; if (num !== 1'b1) begin n_bad++; $display("FAIL num_make: got %b want 1", num); end
    key(KC_NUM, 1'b1);
    wait_tx(1);
    rx(RSP_ACK);
    wait_tx(2);
    n_cmp++; if (txb(1) !== 8'h02) begin n_bad++; $display("FAIL num_led: got %h want 02", txb(1)); end
    rx(RSP_ACK);
    idle(5);
`else
    n_cmp++; if (num !== 1'b0) begin n_bad++; $display("FAIL num_disabled: got %b want 0", num); end
    key(KC_NUM, 1'b1);
    key(KC_SCROLL, 1'b0);
    idle(20);
    n_cmp++; if (txq.size() != 0 || busy !== 1'b0 || scroll !== 1'b0) begin n_bad++; $display("FAIL num_no_seq: got ntx=%0d busy=%b scroll=%b want 0/0/0", txq.size(), busy, scroll); end
`endif
  endtask

  task automatic test_reset_mid;
    int e0;
    txq.delete(); txc.delete();
    e0 = errs;
    key(KC_LSHIFT, 1'b0);
    key(KC_CAPS, 1'b0); key(KC_CAPS, 1'b1);
    wait_tx(1);
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({caps, shift, alt, num, scroll, busy, kif.tx_stb} !== 7'b0 || kif.tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_clear: got %b data=%h want 0000000 00", {caps, shift, alt, num, scroll, busy, kif.tx_stb}, kif.tx_data); end
    idle(2);
    rst_n = 1'b1;
    idle(20);
    n_cmp++; if (errs != e0 || txq.size() != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_silent: got err=%0d ntx=%0d busy=%b want 0/1/0", errs - e0, txq.size(), busy); end
  endtask

  initial begin
    kif.key_data_stb = 1'b0; kif.key_broken = 1'b0; kif.key_data = 8'h00;
    kif.rx_stb = 1'b0; kif.rx_data = 8'h00; kif.tx_ready = 1'b1;
    idle(3);
    test_reset;
    rst_n = 1'b1;
    idle(2);
    test_caps;
    test_typematic;
    test_shift_alt;
    test_resend;
    test_timeout;
    test_num;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
